// File: rtl/bin2bcd_seq_ctrl.sv
// Sequential binary-to-BCD converter (double-dabble, one bit per cycle) with valid/ready on both sides.
// Optional macro BIN2BCD_SIGNED_EN: treat in_bin as two's complement and report the sign on out_neg.
module bin2bcd_seq_ctrl #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      in_bin,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   out_bcd,
    output logic                  out_neg,
    output logic                  busy
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam int BW = 4 * DIGITS;

    function automatic longint pow10(input int n);
        longint r;
        r = 1;
        for (int i = 0; i < n; i++) r = r * 10;
        return r;
    endfunction

    generate
        if (WIDTH < 4 || WIDTH > 16) begin : g_bad_width
            $error("bin2bcd_seq_ctrl: WIDTH must be in 4..16");
        end
        if (pow10(DIGITS) <= (longint'(1) << WIDTH)) begin : g_bad_digits
            $error("bin2bcd_seq_ctrl: DIGITS too small for WIDTH");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

    state_e          state_q, state_d;
    logic [WIDTH-1:0] bin_q, bin_d;
    logic [BW-1:0]   bcd_q, bcd_d, bcd_adj;
    logic [BW-1:0]   out_bcd_q, out_bcd_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0] load_val;

`ifdef BIN2BCD_SIGNED_EN
    logic load_neg, sign_q, sign_d, neg_q, neg_d;
    // Negating the most negative value yields itself, which reads correctly as an unsigned magnitude.
    assign load_neg = in_bin[WIDTH-1];
    assign load_val = load_neg ? -in_bin : in_bin;
    assign out_neg  = neg_q;
`else
    assign load_val = in_bin;
    assign out_neg  = 1'b0;
`endif

    // Add-3 correction on every digit >= 5 ahead of the shift.
    generate
        for (genvar g = 0; g < DIGITS; g++) begin : g_adj
            assign bcd_adj[4*g +: 4] = (bcd_q[4*g +: 4] >= 4'd5) ? bcd_q[4*g +: 4] + 4'd3
                                                                : bcd_q[4*g +: 4];
        end
    endgenerate

    always_comb begin
        state_d   = state_q;
        bin_d     = bin_q;
        bcd_d     = bcd_q;
        cnt_d     = cnt_q;
        out_bcd_d = out_bcd_q;
`ifdef BIN2BCD_SIGNED_EN
        sign_d    = sign_q;
        neg_d     = neg_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    bin_d   = load_val;
                    bcd_d   = '0;
                    cnt_d   = '0;
                    state_d = SHIFT;
`ifdef BIN2BCD_SIGNED_EN
                    sign_d  = load_neg;
`endif
                end
            end
            SHIFT: begin
                {bcd_d, bin_d} = {bcd_adj[BW-2:0], bin_q, 1'b0};
                cnt_d          = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d   = DONE;
                    out_bcd_d = {bcd_adj[BW-2:0], bin_q[WIDTH-1]};
`ifdef BIN2BCD_SIGNED_EN
                    neg_d     = sign_q;
`endif
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            bin_q     <= '0;
            bcd_q     <= '0;
            cnt_q     <= '0;
            out_bcd_q <= '0;
`ifdef BIN2BCD_SIGNED_EN
            sign_q    <= 1'b0;
            neg_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            bin_q     <= bin_d;
            bcd_q     <= bcd_d;
            cnt_q     <= cnt_d;
            out_bcd_q <= out_bcd_d;
`ifdef BIN2BCD_SIGNED_EN
            sign_q    <= sign_d;
            neg_q     <= neg_d;
`endif
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign out_bcd   = out_bcd_q;
endmodule

// File: tb/tb_bin2bcd_seq_ctrl.sv
// Scoreboard bench for bin2bcd_seq_ctrl (WIDTH=8, DIGITS=3); honours BIN2BCD_SIGNED_EN.
module tb_bin2bcd_seq_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic [7:0]  in_bin = 8'd0;
    logic        in_ready, out_valid, out_neg, busy;
    logic [11:0] out_bcd;

    typedef struct packed {
        logic [11:0] bcd;
        logic        neg;
    } exp_t;
    exp_t sbq[$];
    int total = 0;
    int bad = 0;

`ifdef BIN2BCD_SIGNED_EN
    localparam logic [11:0] E255 = 12'h001;
    localparam logic        N255 = 1'b1;
    localparam logic [11:0] E80  = 12'h128;
    localparam logic        N80  = 1'b1;
`else
    localparam logic [11:0] E255 = 12'h255;
    localparam logic        N255 = 1'b0;
    localparam logic [11:0] E80  = 12'h128;
    localparam logic        N80  = 1'b0;
`endif

    bin2bcd_seq_ctrl #(.WIDTH(8), .DIGITS(3)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_bin(in_bin),
        .out_valid(out_valid), .out_ready(out_ready), .out_bcd(out_bcd), .out_neg(out_neg),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Monitor: a handshake completes on the next rising edge whenever valid&ready is seen here.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            exp_t e;
            if (sbq.size() == 0) begin
                chk("unexpected result", int'(out_bcd), -1);
            end else begin
                e = sbq.pop_front();
                chk("result bcd", int'(out_bcd), int'(e.bcd));
                chk("result neg", int'(out_neg), int'(e.neg));
            end
        end
    end

    task automatic wait_idle(input string nm);
        int w = 0;
        while (!in_ready && w < 40) begin
            @(posedge clk); #1;
            w++;
        end
        chk({nm, " idle wait"}, int'(in_ready), 1);
    endtask

    task automatic send(input logic [7:0] v, input logic [11:0] eb, input logic en, input string nm);
        int lat = 0;
        wait_idle(nm);
        in_bin   = v;
        in_valid = 1'b1;
        sbq.push_back('{bcd: eb, neg: en});
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk({nm, " busy"}, int'(busy), 1);
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({nm, " latency"}, lat, 8);
    endtask

    initial begin
        bit ok;
        #1;
        chk("rst in_ready", int'(in_ready), 1);
        chk("rst out_valid", int'(out_valid), 0);
        chk("rst out_bcd", int'(out_bcd), 0);
        chk("rst out_neg", int'(out_neg), 0);
        chk("rst busy", int'(busy), 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // 1: zero
        send(8'd0, 12'h000, 1'b0, "t1 zero");

        // 2: 255, then in_ready one cycle after the output handshake
        send(8'd255, E255, N255, "t2 255");
        @(posedge clk); #1;
        chk("t2 in_ready after hs", int'(in_ready), 1);
        chk("t2 out_valid dropped", int'(out_valid), 0);

        // 3: back-pressure with a stray in_valid while DONE
        out_ready = 1'b0;
        send(8'd109, 12'h109, 1'b0, "t3 109");
        ok = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (out_valid !== 1'b1 || out_bcd !== 12'h109 || in_ready !== 1'b0) ok = 1'b0;
            in_valid = (i == 5);
            in_bin   = 8'd5;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        chk("t3 hold stable", int'(ok), 1);
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("t3 released", int'(out_valid), 0);
        ok = 1'b1;
        for (int i = 0; i < 12; i++) begin
            if (out_valid !== 1'b0 || in_ready !== 1'b1) ok = 1'b0;
            @(posedge clk); #1;
        end
        chk("t3 single result", int'(ok), 1);

        // 4: reset in the middle of a conversion of 200
        in_bin   = 8'd200;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("t4 rst in_ready", int'(in_ready), 1);
        chk("t4 rst out_valid", int'(out_valid), 0);
        chk("t4 rst busy", int'(busy), 0);
        chk("t4 rst out_bcd", int'(out_bcd), 0);
        chk("t4 rst out_neg", int'(out_neg), 0);
        @(posedge clk); #1 rst = 1'b0;
        send(8'd37, 12'h037, 1'b0, "t4 37");

        // 5: back-to-back
        send(8'd1, 12'h001, 1'b0, "t5 1");
        send(8'd99, 12'h099, 1'b0, "t5 99");
        send(8'd100, 12'h100, 1'b0, "t5 100");

        // 6: sign boundaries (plain magnitudes when unsigned)
        send(8'h80, E80, N80, "t6 80");
        send(8'hFF, E255, N255, "t6 FF");
        send(8'h7F, 12'h127, 1'b0, "t6 7F");

        repeat (4) @(posedge clk);
        #1;
        chk("scoreboard drained", sbq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: timeout reached, want finish");
        $fatal(1);
    end
endmodule

// File: doc/bin2bcd_seq_ctrl.md
Name: bin2bcd_seq_ctrl

Overview:
Sequential binary-to-decimal (BCD) converter controller. It accepts one binary word over a valid/ready handshake and runs a shift-and-add-3 (double-dabble) sequence for WIDTH cycles. It then presents packed BCD digits over a second valid/ready handshake. It replaces wide combinational binary-to-decimal logic in paths that feed display and UART formatting.

Parameters:
WIDTH, 8, binary input width in bits; legal range 4..16.
DIGITS, 3, number of BCD output digits; must satisfy 10^DIGITS > 2^WIDTH (checked by elaboration-time assertion).

Ports:
clk  input  1  system clock; all state changes on rising edge.
rst  input  1  asynchronous, active-high reset.
in_valid  input  1  binary word on in_bin is valid.
in_ready  output  1  controller can accept a word; high only in IDLE.
in_bin  input  WIDTH  binary value to convert.
out_valid  output  1  out_bcd and out_neg hold a finished result.
out_ready  input  1  consumer accepts the result.
out_bcd  output  4*DIGITS  packed BCD; bits [3:0] are the ones digit, [7:4] the tens digit, and so on.
out_neg  output  1  result sign (see Optional Feature); 0 when the feature is compiled out.
busy  output  1  high in SHIFT and DONE.

Behaviour:
- Reset values: state=IDLE, in_ready=1, out_valid=0, out_bcd=0, out_neg=0, busy=0, internal shift register=0, counter=0. Reset acts immediately and asynchronously; a conversion interrupted by reset is discarded with no output.
- States:
  - IDLE: in_ready=1. On a rising edge with in_valid=1, latch in_bin into the binary shift register, clear the BCD register and counter, and go to SHIFT.
  - SHIFT: in_ready=0, busy=1. Each cycle, add 3 to every BCD digit that is >= 5, then shift {bcd, bin} left by 1 so that bin's MSB enters the BCD LSB. Counter increments. After the WIDTH-th shift, go to DONE.
  - DONE: out_valid=1, and out_bcd is stable and registered. On a rising edge with out_ready=1, go to IDLE and drop out_valid.
- Latency: out_valid rises exactly WIDTH rising edges after the accepting edge. Minimum throughput is one word per WIDTH+2 cycles.
- Back-pressure: while out_ready=0 in DONE, out_valid, out_bcd and out_neg hold indefinitely.
- in_valid while busy is ignored; no input is latched outside IDLE.
- out_valid does not fall combinationally; it falls on the edge where out_ready is sampled high.
- The counter is $clog2(WIDTH+1) bits wide and never wraps; it is cleared on accept.
- out_bcd is unchanged except on the SHIFT→DONE transition, where the final BCD register value is loaded.

Optional Feature:
Macro BIN2BCD_SIGNED_EN.
- Defined: in_bin is two's complement. On accept, if in_bin[WIDTH-1]=1, the magnitude (-in_bin) is loaded into the shift register and the sign is latched. The most negative value (e.g. 8'h80) converts to 128. out_neg is driven from the latched sign when the controller enters DONE. Timing and handshake are unchanged.
- Undefined: in_bin is unsigned and out_neg is tied to 0.

Test Plan:
1. Reset, then in_bin=8'd0 with in_valid pulsed -> out_valid after 8 edges, out_bcd=12'h000, out_neg=0.
2. in_bin=8'd255 with out_ready=1 -> out_bcd=12'h255 exactly 8 edges after accept; in_ready returns to 1 one cycle after the out handshake.
3. in_bin=8'd109, out_ready held 0 for 20 cycles -> out_valid and out_bcd=12'h109 stable throughout; a second in_valid pulse during that time is not accepted; releasing out_ready yields one result only.
4. Assert rst 4 cycles into a conversion of 8'd200 -> all outputs immediately at reset values; the next conversion of 8'd37 gives 12'h037 with no residue.
5. Back-to-back words 8'd1, 8'd99, 8'd100 with out_ready=1 -> results 12'h001, 12'h099, 12'h100 in order, each after 8-edge latency.
6. With BIN2BCD_SIGNED_EN: 8'h80 -> out_neg=1, out_bcd=12'h128; 8'hFF -> out_neg=1, 12'h001; 8'h7F -> out_neg=0, 12'h127.
